// File: rtl/div3_pkg.sv
// Shared definitions for the divisible-by-three datapath.
// Holds the serializer state encoding and the default word width used by
// word_serializer_msb and the downstream remainder stage.
package div3_pkg;

    // Default serial word width.
    localparam int unsigned DIV3_WORD_W = 8;

    // Serializer state; 2-bit encoding leaves two unused codes that decode to idle.
    typedef enum logic [1:0] {
        SER_IDLE  = 2'd0,
        SER_SHIFT = 2'd1
    } ser_state_t;

endpackage

// File: rtl/word_serializer_msb.sv
// word_serializer_msb
// Parallel-to-serial front end: takes WIDTH-bit words on a valid/ready handshake
// and emits them MSB first, one bit per cycle, with per-bit valid and
// first/last markers. Downstream backpressure stalls the shift without loss.
//
// Ports
//   clk          clock, rising edge
//   reset_n      asynchronous active-low reset
//   in_valid_i   word available on in_data_i
//   in_data_i    word to serialize (MSB sent first)
//   in_ready_o   block accepts a word this cycle
//   x_o          current serial bit
//   x_valid_o    x_o holds a real bit
//   x_first_o    x_o is the MSB of a word
//   x_last_o     x_o is the LSB of a word
//   x_ready_i    downstream consumes x_o this cycle
module word_serializer_msb
    import div3_pkg::*;
#(
    parameter int unsigned WIDTH = DIV3_WORD_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid_i,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             in_ready_o,
    output logic             x_o,
    output logic             x_valid_o,
    output logic             x_first_o,
    output logic             x_last_o,
    input  logic             x_ready_i
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CntMax = CW'(WIDTH - 1);

    ser_state_t       state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic cnt_zero;
    assign cnt_zero = (cnt_q == '0);

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        cnt_d      = cnt_q;
        in_ready_o = 1'b0;

        unique case (state_q)
            SER_IDLE: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    shreg_d = in_data_i;
                    cnt_d   = CntMax;
                    state_d = SER_SHIFT;
                end
            end
            SER_SHIFT: begin
                // Accepting on the last consumed bit lets words run back to back.
                in_ready_o = cnt_zero && x_ready_i;
                if (x_ready_i) begin
                    if (!cnt_zero) begin
                        shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                        cnt_d   = cnt_q - CW'(1);
                    end else if (in_valid_i) begin
                        shreg_d = in_data_i;
                        cnt_d   = CntMax;
                    end else begin
                        shreg_d = '0;
                        cnt_d   = '0;
                        state_d = SER_IDLE;
                    end
                end
            end
            default: begin
                // Unused encodings recover to idle.
                shreg_d = '0;
                cnt_d   = '0;
                state_d = SER_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= SER_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    assign x_valid_o = (state_q == SER_SHIFT);
    assign x_o       = x_valid_o && shreg_q[WIDTH-1];
    assign x_first_o = x_valid_o && (cnt_q == CntMax);
    assign x_last_o  = x_valid_o && cnt_zero;

endmodule
